// File: rtl/tdc_multichannel_timestamper.sv
// Multi-channel TDC back end: stamps fine codes with a latency-corrected coarse count,
// merges channels round-robin into a first-word-fall-through FIFO, and inserts rollover markers.
module tdc_multichannel_timestamper #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned FINE_BITS    = 8,
    parameter int unsigned COARSE_BITS  = 16,
    parameter int unsigned FINE_LATENCY = 3,
    parameter int unsigned FIFO_DEPTH   = 16,
    localparam int unsigned CH_BITS     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned W           = 1 + CH_BITS + COARSE_BITS + FINE_BITS,
    localparam int unsigned LVL_BITS    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [CHANNELS-1:0]           hit_valid,
    input  logic [CHANNELS*FINE_BITS-1:0] hit_fine,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [W-1:0]                  out_data,
    output logic [15:0]                   drop_count,
    output logic [CHANNELS-1:0]           drop_flags,
    output logic [LVL_BITS-1:0]           fifo_level
);

    localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);

    logic [COARSE_BITS-1:0] cnt_q, cnt_d;
    logic                   roll_q, roll_d;
    logic [CH_BITS-1:0]     ptr_q, ptr_d;
    logic [CHANNELS-1:0]    full_q, full_d;
    logic [COARSE_BITS-1:0] coarse_q [CHANNELS];
    logic [COARSE_BITS-1:0] coarse_d [CHANNELS];
    logic [FINE_BITS-1:0]   fine_q   [CHANNELS];
    logic [FINE_BITS-1:0]   fine_d   [CHANNELS];
    logic [CHANNELS-1:0]    flags_q, flags_d;
    logic [15:0]            drops_q, drops_d;

    logic [W-1:0]           mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_BITS-1:0]    level_q, level_d;
    logic                   valid_q, valid_d;
    logic [W-1:0]           data_q, data_d;

    logic                   wrap, wr_en, rd_en, found, drop_any;
    logic [W-1:0]           wdata;
    logic [CHANNELS-1:0]    grant;
    logic [CH_BITS-1:0]     idx;
    logic [COARSE_BITS-1:0] stamp;

    // Coarse counter and arbiter: a pending rollover marker outranks every hit.
    always_comb begin
        wrap   = enable && (cnt_q == '1);
        cnt_d  = enable ? cnt_q + COARSE_BITS'(1) : cnt_q;
        wr_en  = 1'b0;
        wdata  = '0;
        grant  = '0;
        ptr_d  = ptr_q;
        found  = 1'b0;
        idx    = '0;
        roll_d = roll_q;
        if (level_q != LVL_BITS'(FIFO_DEPTH)) begin
            if (roll_q) begin
                wr_en  = 1'b1;
                wdata  = {1'b1, {(W-1){1'b0}}};
                roll_d = 1'b0;
            end else begin
                for (int unsigned k = 1; k <= CHANNELS; k++) begin
                    idx = CH_BITS'((32'(ptr_q) + k) % CHANNELS);
                    if (!found && full_q[idx]) begin
                        found      = 1'b1;
                        wr_en      = 1'b1;
                        grant[idx] = 1'b1;
                        ptr_d      = idx;
                        wdata      = {1'b0, idx, coarse_q[idx], fine_q[idx]};
                    end
                end
            end
        end
        // A wrap while a marker is already pending merges into it.
        roll_d = roll_d | wrap;
    end

    // Holding registers: a register granted this cycle may reload without dropping.
    always_comb begin
        stamp    = cnt_q - COARSE_BITS'(FINE_LATENCY);
        drop_any = 1'b0;
        flags_d  = flags_q;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            full_d[i]   = full_q[i] & ~grant[i];
            coarse_d[i] = coarse_q[i];
            fine_d[i]   = fine_q[i];
            if (enable && hit_valid[i]) begin
                if (full_q[i] && !grant[i]) begin
                    drop_any   = 1'b1;
                    flags_d[i] = 1'b1;
                end else begin
                    full_d[i]   = 1'b1;
                    coarse_d[i] = stamp;
                    fine_d[i]   = hit_fine[i*FINE_BITS +: FINE_BITS];
                end
            end
        end
        drops_d = (drop_any && (drops_q != 16'hFFFF)) ? drops_q + 16'd1 : drops_q;
    end

    // FIFO bookkeeping; the registered head bypasses memory when the write lands at the head.
    always_comb begin
        rd_en    = valid_q && out_ready;
        wr_ptr_d = wr_ptr_q + PTR_BITS'(wr_en);
        rd_ptr_d = rd_ptr_q + PTR_BITS'(rd_en);
        level_d  = level_q + LVL_BITS'(wr_en) - LVL_BITS'(rd_en);
        valid_d  = (level_d != '0);
        data_d   = data_q;
        if (valid_d) begin
            data_d = (wr_en && (wr_ptr_q == rd_ptr_d)) ? wdata : mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            roll_q   <= 1'b0;
            ptr_q    <= '0;
            full_q   <= '0;
            flags_q  <= '0;
            drops_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                coarse_q[i] <= '0;
                fine_q[i]   <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            roll_q   <= roll_d;
            ptr_q    <= ptr_d;
            full_q   <= full_d;
            flags_q  <= flags_d;
            drops_q  <= drops_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                coarse_q[i] <= coarse_d[i];
                fine_q[i]   <= fine_d[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign drop_count = drops_q;
    assign drop_flags = flags_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_tdc_multichannel_timestamper.sv
// Directed bench: default instance (16-bit coarse) plus a 4-bit coarse instance for rollover cases.
module tb_tdc_multichannel_timestamper;

    localparam int unsigned W0 = 27;
    localparam int unsigned W1 = 15;

    logic          clock;
    logic          reset;
    logic          enable, out_ready, enable_w, out_ready_w;
    logic [3:0]    hit_valid, hit_valid_w;
    logic [31:0]   hit_fine, hit_fine_w;
    logic          out_valid, out_valid_w;
    logic [W0-1:0] out_data;
    logic [W1-1:0] out_data_w;
    logic [15:0]   drop_count, drop_count_w;
    logic [3:0]    drop_flags, drop_flags_w;
    logic [4:0]    fifo_level, fifo_level_w;

    int total;
    int bad;

    tdc_multichannel_timestamper dut (
        .clock(clock), .reset(reset), .enable(enable),
        .hit_valid(hit_valid), .hit_fine(hit_fine),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_count(drop_count), .drop_flags(drop_flags), .fifo_level(fifo_level)
    );

    tdc_multichannel_timestamper #(.COARSE_BITS(4)) dut_w (
        .clock(clock), .reset(reset), .enable(enable_w),
        .hit_valid(hit_valid_w), .hit_fine(hit_fine_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w),
        .drop_count(drop_count_w), .drop_flags(drop_flags_w), .fifo_level(fifo_level_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic hard_reset();
        reset = 1'b1;
        enable = 1'b0; enable_w = 1'b0;
        out_ready = 1'b0; out_ready_w = 1'b0;
        hit_valid = '0; hit_valid_w = '0;
        hit_fine = '0; hit_fine_w = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        hard_reset();
        reset = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%h want=0", out_valid); end
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drops got=%0d want=0", drop_count); end
        total++; if (drop_flags !== 4'd0) begin bad++; $display("FAIL reset_flags got=%h want=0", drop_flags); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
        total++; if (out_valid_w !== 1'b0) begin bad++; $display("FAIL reset_valid_w got=%h want=0", out_valid_w); end
        reset = 1'b0;
    endtask

    task automatic test_single_hit();
        logic [W0-1:0] exp;
        hard_reset();
        enable = 1'b1;
        repeat (10) step();
        hit_valid = 4'b0100;
        hit_fine  = 32'h005A_0000;
        step();
        hit_valid = '0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%h want=0", out_valid); end
        step();
        exp = {1'b0, 2'd2, 16'd7, 8'h5A};
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%h want=1", out_valid); end
        total++; if (out_data !== exp) begin bad++; $display("FAIL single_data got=%h want=%h", out_data, exp); end
        total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL single_level got=%0d want=1", fifo_level); end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%h want=0", out_valid); end
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL single_pop_level got=%0d want=0", fifo_level); end
        out_ready = 1'b0;
    endtask

    task automatic test_all_channels();
        logic [W0-1:0] exp;
        int ch;
        hard_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        hit_valid = 4'hF;
        hit_fine  = 32'h0403_0201;
        step();
        hit_valid = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            ch  = (k + 1) % 4;
            exp = {1'b0, 2'(ch), 16'hFFFD, 8'(ch + 1)};
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%h want=1", k, out_valid); end
            total++; if (out_data !== exp) begin bad++; $display("FAIL rr_data[%0d] got=%h want=%h", k, out_data, exp); end
            total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL rr_level[%0d] got=%0d want=1", k, fifo_level); end
        end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rr_empty got=%h want=0", out_valid); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL rr_drops got=%0d want=0", drop_count); end
        total++; if (drop_flags !== 4'd0) begin bad++; $display("FAIL rr_flags got=%h want=0", drop_flags); end
        out_ready = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_rollover();
        logic exp_v;
        hard_reset();
        enable_w = 1'b1;
        out_ready_w = 1'b1;
        hit_fine_w = 32'h0000_0033;
        for (int n = 1; n <= 40; n++) begin
            hit_valid_w = (n == 2) ? 4'b0001 : 4'b0000;
            step();
            hit_valid_w = '0;
            exp_v = (n == 3) || (n == 17) || (n == 33);
            total++; if (out_valid_w !== exp_v) begin bad++; $display("FAIL roll_valid[%0d] got=%h want=%h", n, out_valid_w, exp_v); end
            if (n == 3) begin
                total++; if (out_data_w !== {1'b0, 2'd0, 4'd14, 8'h33}) begin bad++; $display("FAIL roll_stamp got=%h want=%h", out_data_w, {1'b0, 2'd0, 4'd14, 8'h33}); end
            end
            if (n == 17 || n == 33) begin
                total++; if (out_data_w !== 15'h4000) begin bad++; $display("FAIL roll_marker[%0d] got=%h want=4000", n, out_data_w); end
            end
        end
        enable_w = 1'b0;
        out_ready_w = 1'b0;
    endtask

    task automatic test_drop_and_drain();
        logic [W0-1:0] exp;
        hard_reset();
        enable = 1'b1;
        hit_valid = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            hit_fine = 32'(k);
            step();
            if (k == 17) begin
                exp = {1'b0, 2'd0, 16'hFFFD, 8'd1};
                total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL fill_level got=%0d want=16", fifo_level); end
                total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL fill_drops got=%0d want=0", drop_count); end
                total++; if (out_data !== exp) begin bad++; $display("FAIL stall_head got=%h want=%h", out_data, exp); end
            end
            if (k >= 18) begin
                total++; if (drop_count !== 16'(k - 17)) begin bad++; $display("FAIL drop_count[%0d] got=%0d want=%0d", k, drop_count, k - 17); end
                total++; if (drop_flags !== 4'b0001) begin bad++; $display("FAIL drop_flags[%0d] got=%h want=1", k, drop_flags); end
            end
        end
        hit_valid = '0;
        out_ready = 1'b1;
        for (int j = 1; j <= 17; j++) begin
            exp = {1'b0, 2'd0, 16'(j - 4), 8'(j)};
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%h want=1", j, out_valid); end
            total++; if (out_data !== exp) begin bad++; $display("FAIL drain_data[%0d] got=%h want=%h", j, out_data, exp); end
            step();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%h want=0", out_valid); end
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL drain_level got=%0d want=0", fifo_level); end
        total++; if (drop_count !== 16'd3) begin bad++; $display("FAIL drain_drops got=%0d want=3", drop_count); end
        out_ready = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_wrap_while_full();
        logic [W1-1:0] exp;
        int b;
        int ch;
        hard_reset();
        for (int n = 1; n <= 20; n++) begin
            b = (n - 1) / 5;
            enable_w    = (n % 5 == 1);
            hit_valid_w = (n % 5 == 1) ? 4'hF : 4'h0;
            hit_fine_w  = {8'(b*4 + 3), 8'(b*4 + 2), 8'(b*4 + 1), 8'(b*4)};
            step();
        end
        total++; if (fifo_level_w !== 5'd16) begin bad++; $display("FAIL wf_fill_level got=%0d want=16", fifo_level_w); end
        enable_w = 1'b1;
        hit_fine_w = 32'h00EE_0000;
        for (int n = 21; n <= 35; n++) begin
            hit_valid_w = (n == 22) ? 4'b0100 : 4'b0000;
            step();
        end
        hit_valid_w = '0;
        total++; if (fifo_level_w !== 5'd16) begin bad++; $display("FAIL wf_hold_level got=%0d want=16", fifo_level_w); end
        total++; if (drop_count_w !== 16'd0) begin bad++; $display("FAIL wf_drops got=%0d want=0", drop_count_w); end
        enable_w = 1'b0;
        out_ready_w = 1'b1;
        for (int j = 0; j < 18; j++) begin
            if (j < 16) begin
                b   = j / 4;
                ch  = ((j % 4) + 1) % 4;
                exp = {1'b0, 2'(ch), 4'(b + 13), 8'(b*4 + ch)};
            end else if (j == 16) begin
                exp = 15'h4000;
            end else begin
                exp = {1'b0, 2'd2, 4'd2, 8'hEE};
            end
            total++; if (out_valid_w !== 1'b1) begin bad++; $display("FAIL wf_valid[%0d] got=%h want=1", j, out_valid_w); end
            total++; if (out_data_w !== exp) begin bad++; $display("FAIL wf_data[%0d] got=%h want=%h", j, out_data_w, exp); end
            step();
        end
        total++; if (out_valid_w !== 1'b0) begin bad++; $display("FAIL wf_empty got=%h want=0", out_valid_w); end
        out_ready_w = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        logic [W0-1:0] exp;
        hard_reset();
        enable = 1'b1;
        hit_valid = 4'b0001;
        hit_fine = 32'h0000_0011;
        repeat (20) step();
        total++; if (drop_count !== 16'd3) begin bad++; $display("FAIL mid_pre_drops got=%0d want=3", drop_count); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%h want=0", out_valid); end
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL mid_level got=%0d want=0", fifo_level); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL mid_drops got=%0d want=0", drop_count); end
        total++; if (drop_flags !== 4'd0) begin bad++; $display("FAIL mid_flags got=%h want=0", drop_flags); end
        hit_valid = 4'b1000;
        hit_fine = 32'h7700_0000;
        out_ready = 1'b1;
        step();
        hit_valid = '0;
        step();
        exp = {1'b0, 2'd3, 16'hFFFD, 8'h77};
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_restart_valid got=%h want=1", out_valid); end
        total++; if (out_data !== exp) begin bad++; $display("FAIL mid_restart_data got=%h want=%h", out_data, exp); end
        out_ready = 1'b0;
        enable = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_hit();
        test_all_channels();
        test_rollover();
        test_drop_and_drain();
        test_wrap_while_full();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
